// File: rtl/axis_vid_pkg.sv
// rtl/axis_vid_pkg.sv - shared encodings and helpers for the video pattern generator
package axis_vid_pkg;

   typedef enum logic [1:0] {
      PAT_COUNTER = 2'd0,
      PAT_HRAMP   = 2'd1,
      PAT_CONST   = 2'd2,
      PAT_CHECKER = 2'd3
   } pat_mode_e;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_SEND  = 3'd2;
   localparam logic [2:0] ST_LGAP  = 3'd3;
   localparam logic [2:0] ST_FGAP  = 3'd4;

   // Bits needed to count 0..value-1, never less than one.
   function automatic int clogb2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/vid_pattern_lane.sv
// rtl/vid_pattern_lane.sv - combinational pixel value for one lane of a beat
module vid_pattern_lane
   import axis_vid_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int PX_WIDTH    = (PIXEL_WIDTH > 5) ? PIXEL_WIDTH : 5
)
(
   input  logic [1:0]             mode,
   input  logic [PX_WIDTH-1:0]    p,
   input  logic                   y4,
   input  logic [PIXEL_WIDTH-1:0] f,
   input  logic [PIXEL_WIDTH-1:0] fill,
   input  logic [PIXEL_WIDTH-1:0] cnt,
   output logic [PIXEL_WIDTH-1:0] pixel
);

   always_comb begin
      pixel = '0;
      case (pat_mode_e'(mode))
         PAT_COUNTER: pixel = cnt;
         PAT_HRAMP:   pixel = p[PIXEL_WIDTH-1:0] + f;
         PAT_CONST:   pixel = fill;
         PAT_CHECKER: pixel = (p[4] ^ y4) ? '1 : '0;
         default:     pixel = '0;
      endcase
   end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// rtl/axis_video_pattern_gen.sv - AXI4-Stream video test-pattern master with blanking and clean stop
module axis_video_pattern_gen
   import axis_vid_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int PIXEL_WIDTH          = 8,
   parameter int PIXELS_PER_BEAT      = 4,
   parameter int PIXELS_HORIZONTAL    = 1280,
   parameter int PIXELS_VERTICAL      = 1024,
   parameter int C_M_START_COUNT      = 3,
   parameter int LINE_GAP             = 0,
   parameter int FRAME_GAP            = 300
)
(
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESET,
   input  logic                                enable,
   input  logic [1:0]                          mode,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     fill,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   output logic                                M_AXIS_TUSER,
   input  logic                                M_AXIS_TREADY,
   output logic [15:0]                         frame_cnt,
   output logic                                busy
);

   localparam int W       = C_M_AXIS_TDATA_WIDTH;
   localparam int PW      = PIXEL_WIDTH;
   localparam int PXW     = (PW > 5) ? PW : 5;
   localparam int BPL     = PIXELS_HORIZONTAL / PIXELS_PER_BEAT;
   localparam int BXW     = clogb2(BPL);
   localparam int LYW     = clogb2(PIXELS_VERTICAL);
   localparam int GAP_MAX = (FRAME_GAP > LINE_GAP) ?
                            ((FRAME_GAP > C_M_START_COUNT) ? FRAME_GAP : C_M_START_COUNT) :
                            ((LINE_GAP > C_M_START_COUNT) ? LINE_GAP : C_M_START_COUNT);
   localparam int GW      = clogb2(GAP_MAX + 1);

   localparam logic [BXW-1:0] BX_LAST    = BXW'(BPL - 1);
   localparam logic [LYW-1:0] LY_LAST    = LYW'(PIXELS_VERTICAL - 1);
   localparam logic [GW-1:0]  START_LOAD = (C_M_START_COUNT > 0) ? GW'(C_M_START_COUNT - 1) : '0;
   localparam logic [GW-1:0]  LGAP_LOAD  = (LINE_GAP > 0) ? GW'(LINE_GAP - 1) : '0;
   localparam logic [GW-1:0]  FGAP_LOAD  = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;
   localparam logic [31:0]    PPB32      = 32'(PIXELS_PER_BEAT);

   logic [2:0]     state, state_n;
   logic [BXW-1:0] beat_x, bx_n;
   logic [LYW-1:0] line_y, ly_n;
   logic [15:0]    frame_cnt_q, fc_n;
   logic [GW-1:0]  gap_cnt, gap_n;
   logic           load, first;
   logic [1:0]     mode_q, mode_sel;
   logic [W-1:0]   fill_q, fill_sel;
   logic           tvalid_q, tlast_q, tuser_q;
   logic [W-1:0]   tdata_q;
   logic           xfer;

   assign xfer = tvalid_q & M_AXIS_TREADY;

   // The output register always holds the beat addressed by beat_x/line_y; it is
   // reloaded from the next position on each transfer so a line never bubbles.
   always_comb begin
      state_n = state;
      bx_n    = beat_x;
      ly_n    = line_y;
      fc_n    = frame_cnt_q;
      gap_n   = gap_cnt;
      load    = 1'b0;
      first   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_n = ST_START;
               gap_n   = START_LOAD;
            end
         end
         ST_START: begin
            if (gap_cnt == '0) begin
               state_n = ST_SEND;
               load    = 1'b1;
               first   = 1'b1;
               bx_n    = '0;
               ly_n    = '0;
            end else begin
               gap_n = gap_cnt - GW'(1);
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (beat_x == BX_LAST) begin
                  bx_n = '0;
                  if (line_y == LY_LAST) begin
                     ly_n    = '0;
                     fc_n    = frame_cnt_q + 16'd1;
                     state_n = ST_FGAP;
                     gap_n   = FGAP_LOAD;
                  end else begin
                     ly_n = line_y + LYW'(1);
                     if (LINE_GAP == 0) begin
                        load = 1'b1;
                     end else begin
                        state_n = ST_LGAP;
                        gap_n   = LGAP_LOAD;
                     end
                  end
               end else begin
                  bx_n = beat_x + BXW'(1);
                  load = 1'b1;
               end
            end
         end
         ST_LGAP: begin
            if (gap_cnt == '0) begin
               state_n = ST_SEND;
               load    = 1'b1;
            end else begin
               gap_n = gap_cnt - GW'(1);
            end
         end
         ST_FGAP: begin
            if (gap_cnt == '0) begin
               if (enable) begin
                  state_n = ST_SEND;
                  load    = 1'b1;
                  first   = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               gap_n = gap_cnt - GW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Pattern for the beat about to be loaded; the first beat of a frame uses the live mode/fill.
   logic [W-1:0]  cnt_word, pat_word;
   logic [31:0]   px_base;
   logic [PW-1:0] f_lo;
   logic          y4;

   assign mode_sel = first ? mode : mode_q;
   assign fill_sel = first ? fill : fill_q;
   assign px_base  = 32'(bx_n) * PPB32;
   assign f_lo     = PW'(fc_n);
   assign y4       = 1'(32'(ly_n) >> 4);
   assign cnt_word = W'(bx_n) + W'({fc_n[3:0], 12'(ly_n), 16'h0000});

   for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_lane
      logic [PXW-1:0] p;
      assign p = PXW'(px_base + 32'(i));
      vid_pattern_lane #(
         .PIXEL_WIDTH (PW),
         .PX_WIDTH    (PXW)
      ) u_lane (
         .mode  (mode_sel),
         .p     (p),
         .y4    (y4),
         .f     (f_lo),
         .fill  (fill_sel[i*PW +: PW]),
         .cnt   (cnt_word[i*PW +: PW]),
         .pixel (pat_word[i*PW +: PW])
      );
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         state       <= ST_IDLE;
         beat_x      <= '0;
         line_y      <= '0;
         frame_cnt_q <= '0;
         gap_cnt     <= '0;
         mode_q      <= '0;
         fill_q      <= '0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         tlast_q     <= 1'b0;
         tuser_q     <= 1'b0;
      end else begin
         state       <= state_n;
         beat_x      <= bx_n;
         line_y      <= ly_n;
         frame_cnt_q <= fc_n;
         gap_cnt     <= gap_n;
         if (first) begin
            mode_q <= mode;
            fill_q <= fill;
         end
         if (load) begin
            tvalid_q <= 1'b1;
            tdata_q  <= pat_word;
            tlast_q  <= (bx_n == BX_LAST);
            tuser_q  <= first;
         end else if (xfer) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
         end
      end
   end

   assign M_AXIS_TVALID = tvalid_q;
   assign M_AXIS_TDATA  = tdata_q;
   assign M_AXIS_TSTRB  = '1;
   assign M_AXIS_TLAST  = tlast_q;
   assign M_AXIS_TUSER  = tuser_q;
   assign frame_cnt     = frame_cnt_q;
   assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb/tb_axis_video_pattern_gen.sv - scoreboard bench for the video pattern generator
module tb_axis_video_pattern_gen;

   localparam int W      = 32;
   localparam int PPB    = 4;
   localparam int PH     = 16;
   localparam int PV     = 2;
   localparam int BPL    = PH / PPB;
   localparam int FGAP   = 300;
   localparam int LGAP_B = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rst_b, enable, en_b;
   logic [1:0]    mode;
   logic [W-1:0]  fill;
   logic          tready = 1'b1;
   logic          a_tvalid, a_tlast, a_tuser, a_busy;
   logic [W-1:0]  a_tdata;
   logic [W/8-1:0] a_tstrb;
   logic [15:0]   a_fc;

   logic [1:0]    b_mode = 2'd0;
   logic [W-1:0]  b_fill = '0;
   logic          b_ready = 1'b1;
   logic          b_tvalid, b_tlast, b_tuser, b_busy;
   logic [W-1:0]  b_tdata;
   logic [W/8-1:0] b_tstrb;
   logic [15:0]   b_fc;

   axis_video_pattern_gen #(
      .C_M_AXIS_TDATA_WIDTH(W), .PIXEL_WIDTH(8), .PIXELS_PER_BEAT(PPB),
      .PIXELS_HORIZONTAL(PH), .PIXELS_VERTICAL(PV), .C_M_START_COUNT(3),
      .LINE_GAP(0), .FRAME_GAP(FGAP)
   ) u_dut (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .enable(enable), .mode(mode), .fill(fill),
      .M_AXIS_TVALID(a_tvalid), .M_AXIS_TDATA(a_tdata), .M_AXIS_TSTRB(a_tstrb),
      .M_AXIS_TLAST(a_tlast), .M_AXIS_TUSER(a_tuser), .M_AXIS_TREADY(tready),
      .frame_cnt(a_fc), .busy(a_busy)
   );

   axis_video_pattern_gen #(
      .C_M_AXIS_TDATA_WIDTH(W), .PIXEL_WIDTH(8), .PIXELS_PER_BEAT(PPB),
      .PIXELS_HORIZONTAL(PH), .PIXELS_VERTICAL(PV), .C_M_START_COUNT(3),
      .LINE_GAP(LGAP_B), .FRAME_GAP(FGAP)
   ) u_gap (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst_b), .enable(en_b), .mode(b_mode), .fill(b_fill),
      .M_AXIS_TVALID(b_tvalid), .M_AXIS_TDATA(b_tdata), .M_AXIS_TSTRB(b_tstrb),
      .M_AXIS_TLAST(b_tlast), .M_AXIS_TUSER(b_tuser), .M_AXIS_TREADY(b_ready),
      .frame_cnt(b_fc), .busy(b_busy)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        user;
      logic        eof;
      logic [15:0] fc_after;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   f_model = 0;
   int   xfers = 0;
   int   idle_a = 0;
   logic strict_b2b = 1'b0;
   logic rnd_ready = 1'b0;
   logic ready_fixed = 1'b1;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
   endtask

   // Reference pixel rules, evaluated per pixel with plain integer arithmetic.
   function automatic logic [31:0] model_beat(input int m, input logic [31:0] fl,
                                              input int bx, input int y, input int f);
      longint r;
      r = 0;
      case (m)
         0: r = longint'(bx) + longint'(f % 16) * 64'h1000_0000 + longint'(y % 4096) * 65536;
         1: for (int l = 0; l < PPB; l++) r += longint'((bx * PPB + l + f) % 256) << (8 * l);
         2: r = longint'(fl);
         default:
            for (int l = 0; l < PPB; l++)
               if ((((bx * PPB + l) / 16) % 2) != ((y / 16) % 2)) r += 64'hFF << (8 * l);
      endcase
      return r[31:0];
   endfunction

   task automatic push_frame(input int m, input logic [31:0] fl);
      exp_t e;
      for (int y = 0; y < PV; y++) begin
         for (int bx = 0; bx < BPL; bx++) begin
            e.data     = model_beat(m, fl, bx, y, f_model);
            e.last     = (bx == BPL - 1);
            e.user     = (y == 0 && bx == 0);
            e.eof      = (y == PV - 1 && bx == BPL - 1);
            e.fc_after = 16'(f_model + 1);
            exp_q.push_back(e);
         end
      end
      f_model++;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      check(exp_q.size() == 0, {"drain_", tag}, exp_q.size(), 0);
      #1;
   endtask

   task automatic wait_xfers(input int n, input string tag);
      int target = xfers + n;
      int c = 0;
      while (xfers < target && c < 3000) begin
         @(posedge clk);
         c++;
      end
      check(xfers >= target, {"xfer_wait_", tag}, xfers, target);
      #1;
   endtask

   always @(posedge clk) begin
      #2;
      tready = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_fixed;
   end

   logic        hold_v = 1'b0;
   logic [W-1:0] hold_d;
   logic        hold_l, hold_u;
   logic        fc_pend = 1'b0;
   logic [15:0] fc_exp;

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst) begin
         hold_v  = 1'b0;
         fc_pend = 1'b0;
         idle_a  = 0;
      end else begin
         if (fc_pend) begin
            check(a_fc == fc_exp, "frame_cnt", a_fc, fc_exp);
            fc_pend = 1'b0;
         end
         if (hold_v)
            check(a_tvalid && a_tdata == hold_d && a_tlast == hold_l && a_tuser == hold_u,
                  "stall_hold", {a_tvalid, a_tlast, a_tuser, a_tdata}, {1'b1, hold_l, hold_u, hold_d});
         hold_v = a_tvalid && !tready;
         hold_d = a_tdata;
         hold_l = a_tlast;
         hold_u = a_tuser;
         if (a_tvalid && tready) begin
            xfers++;
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_beat", a_tdata, 0);
            end else begin
               e = exp_q.pop_front();
               check(a_tdata == e.data && a_tlast == e.last && a_tuser == e.user &&
                     a_tstrb == 4'hF && a_busy,
                     "beat", {a_tstrb, a_busy, a_tuser, a_tlast, a_tdata},
                     {4'hF, 1'b1, e.user, e.last, e.data});
               if (e.eof) begin
                  fc_pend = 1'b1;
                  fc_exp  = e.fc_after;
               end
            end
            if (strict_b2b && !a_tuser) check(idle_a == 0, "no_bubble", idle_a, 0);
            idle_a = 0;
         end else if (!a_tvalid) begin
            idle_a++;
         end
      end
   end

   int b_idle = 0, b_bx = 0, b_y = 0, b_frames = 0;
   bit b_seen = 1'b0;

   always @(negedge clk) begin : mon_b
      logic eu, el;
      int   eg;
      if (!rst_b) begin
         if (!b_tvalid) begin
            b_idle++;
         end else begin
            eu = (b_bx == 0 && b_y == 0);
            el = (b_bx == BPL - 1);
            eg = eu ? FGAP : ((b_bx == 0) ? LGAP_B : 0);
            if (b_seen || !eu) check(b_idle == eg, "gap_count", b_idle, eg);
            check(b_tuser == eu && b_tlast == el && b_busy && b_tstrb == 4'hF &&
                  b_tdata == model_beat(0, 0, b_bx, b_y, b_frames) && b_fc == 16'(b_frames),
                  "gap_beat", {b_fc, b_tuser, b_tlast, b_tdata},
                  {16'(b_frames), eu, el, model_beat(0, 0, b_bx, b_y, b_frames)});
            b_seen = 1'b1;
            b_idle = 0;
            if (b_bx == BPL - 1) begin
               b_bx = 0;
               if (b_y == PV - 1) begin
                  b_y = 0;
                  b_frames++;
               end else begin
                  b_y++;
               end
            end else begin
               b_bx++;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcount;
      int m;
      logic [31:0] fl;
      rst = 1'b1; rst_b = 1'b1; enable = 1'b0; en_b = 1'b0; mode = 2'd0; fill = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(!a_tvalid && !a_tlast && !a_tuser && a_tdata == 0 && !a_busy && a_fc == 0,
            "reset_state", {a_fc, a_busy, a_tvalid, a_tlast, a_tuser, a_tdata}, 0);
      @(posedge clk); #1;
      rst = 1'b0; rst_b = 1'b0; en_b = 1'b1;

      // CONST frame, mode switched mid-frame; following frame is HRAMP.
      strict_b2b = 1'b1;
      mode = 2'd2; fill = 32'hA5A5_A5A5;
      push_frame(2, fill);
      enable = 1'b1;
      wait_xfers(1, "s6");
      mode = 2'd1; fill = $urandom;
      push_frame(1, fill);
      wait_empty("s6");

      // COUNTER frames, sink always ready.
      mode = 2'd0;
      push_frame(0, 0);
      push_frame(0, 0);
      wait_empty("s2");

      // Random backpressure with random modes; mode/fill scrambled after each frame start.
      strict_b2b = 1'b0;
      rnd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m  = (k == 0) ? 0 : int'($urandom_range(0, 3));
         fl = $urandom;
         mode = 2'(m); fill = fl;
         push_frame(m, fl);
         wait_xfers(1, "s3");
         mode = 2'($urandom); fill = $urandom;
         wait_empty("s3");
      end

      // enable dropped early in a frame: frame completes, then idle.
      rnd_ready = 1'b0; ready_fixed = 1'b1; strict_b2b = 1'b1;
      mode = 2'd0;
      push_frame(0, 0);
      wait_xfers(2, "s5");
      enable = 1'b0;
      wait_empty("s5");
      vcount = 0;
      repeat (FGAP + 50) begin
         @(negedge clk);
         if (a_tvalid) vcount++;
      end
      check(vcount == 0, "stop_no_valid", vcount, 0);
      check(!a_busy, "stop_idle", a_busy, 0);
      check(a_fc == 16'(f_model), "stop_frame_cnt", a_fc, 16'(f_model));

      // Reset mid-frame, then restart.
      @(posedge clk); #1;
      enable = 1'b1;
      push_frame(0, 0);
      wait_xfers(2, "s1");
      ready_fixed = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check(!a_tvalid && !a_busy && a_fc == 0, "reset_midframe", {a_fc, a_busy, a_tvalid}, 0);
      exp_q.delete();
      f_model = 0;
      push_frame(0, 0);
      rst = 1'b0;
      ready_fixed = 1'b1;
      wait_empty("s1");

      check(b_frames >= 3, "gap_dut_frames", b_frames, 3);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
